// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and count-width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Bit count needed to index WIDTH serial steps (0 .. WIDTH-1).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor (d = a - b - bin) built from gate primitives.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_x_b;
  logic a_n;
  logic a_x_b_n;
  logic brw_ab;
  logic brw_in;

  xor g_x0 (a_x_b, a, b);
  xor g_x1 (d, a_x_b, bin);
  not g_n0 (a_n, a);
  not g_n1 (a_x_b_n, a_x_b);
  and g_a0 (brw_ab, a_n, b);
  and g_a1 (brw_in, a_x_b_n, bin);
  or  g_o0 (bout, brw_ab, brw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one full-subtractor cell.
// Optional signed-overflow output V when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    count;
  logic             borrow;
  logic             d_bit;
  logic             bout_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Last shift loads D/Bout from the cell directly so they are valid during the FIN/done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      count  <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      V      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          borrow <= bout_bit;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            D     <= {d_bit, res_sr[WIDTH-1:1]};
            Bout  <= bout_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
            V     <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing D = A - B, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Sequential counterpart to the combinational full-adder lab blocks: the adder's inverse operation, iterated over shift registers.
- Started by a one-cycle start pulse; completion reported by a one-cycle done pulse.
- Used as a lab datapath block driven by a stimulus testbench.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend; captured on accepted start
B  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when D/Bout become valid
D  output  WIDTH  difference A-B mod 2^WIDTH
Bout  output  1  final borrow (1 when A<B unsigned)

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - busy=0, done=0, D=0, Bout=0, internal shift registers/count/borrow=0.
- FSM states: IDLE, SHIFT, FIN.
- IDLE:
  - busy=0.
  - start=1 -> capture A, B into shift regs; borrow=0; count=0; next SHIFT.
  - D/Bout keep their previous values.
- SHIFT (busy=1), per cycle:
  - a, b = current LSBs; d = a^b^borrow; borrow_next = (~a&b) | (~(a^b)&borrow).
  - d shifts into the result reg from the MSB side; operand regs shift right; count++.
  - count==WIDTH-1 -> next FIN.
- FIN:
  - D <= result; Bout <= final borrow; done=1 for exactly this one cycle; busy=0; next IDLE.
- Latency: start accepted in cycle T -> done high in cycle T+WIDTH+1; D/Bout valid from that cycle.
- D/Bout are held until the next completed operation.
- start while busy or in FIN: ignored (not queued). Operands change while busy: no effect.
- start held high continuously: new operation accepted on each return to IDLE, i.e. back-to-back period WIDTH+2 cycles.
- Reset mid-operation: operation aborted; outputs return to reset values; no done pulse.
- Arithmetic: unsigned modulo 2^WIDTH; no width growth. A==B -> D=0, Bout=0.

Optional Feature:
Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: extra output V (1 bit, reset 0).
  - In FIN, V <= signed two's-complement overflow = (A_msb ^ B_msb) & (A_msb ^ D_msb), using captured operands.
  - Held with D.
- Undefined: no V port; no extra logic.

Decomposition:
- Package serial_subtractor_pkg: FSM state enum (IDLE, SHIFT, FIN); count width constant $clog2(WIDTH).
- One sub-module: full_subtractor_cell, combinational.
  - Inputs a, b, bin; outputs d, bout.
  - Gate-level, instantiated once in the datapath.

Test Plan:
- Basic subtract: reset, A=100, B=37, start 1 cycle -> busy for 8 cycles, done in cycle T+9, D=63, Bout=0.
- Borrow case: A=5, B=10 -> D=251 (8'hFB), Bout=1, single done pulse.
- Edge values, each run separately:
  - A=0, B=0 -> D=0, Bout=0.
  - A=8'hFF, B=8'hFF -> D=0, Bout=0.
  - A=0, B=1 -> D=8'hFF, Bout=1.
- Ignored start: A=20, B=3 started; pulse start with A=1, B=1 mid-operation -> single done, D=17; no second done.
- Reset mid-operation: assert rst 4 cycles after start -> busy=0, D=0, Bout=0 immediately; no done; next start (A=9, B=4) gives D=5.
- Overflow, with SERIAL_SUB_OVERFLOW_EN:
  - A=8'h80, B=8'h01 -> D=8'h7F, V=1, Bout=0.
  - A=8'h10, B=8'h01 -> V=0.
